// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared encodings for the SPI byte engine: sequence selectors,
//               command bytes, sequence lengths, FSM state codes and the
//               (select, index) -> byte lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Sequence selectors carried on data_select
    localparam logic [2:0] DS_DUMMY = 3'd0;
    localparam logic [2:0] DS_MEAS  = 3'd1;
    localparam logic [2:0] DS_READ  = 3'd2;
    localparam logic [2:0] DS_SRST  = 3'd3;

    // Command bytes
    localparam logic [7:0] c_cmd_dummy  = 8'h00;
    localparam logic [7:0] c_cmd_meas_0 = 8'h5A;
    localparam logic [7:0] c_cmd_meas_1 = 8'h00;
    localparam logic [7:0] c_cmd_read   = 8'h11;
    localparam logic [7:0] c_cmd_srst_0 = 8'h5E;
    localparam logic [7:0] c_cmd_srst_1 = 8'h52;

    // Fixed sequence lengths (the dummy length is a top-level parameter)
    localparam logic [3:0] c_len_meas = 4'd2;
    localparam logic [3:0] c_len_read = 4'd1;
    localparam logic [3:0] c_len_srst = 4'd2;

    // Engine state encoding
    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_load     = 3'd1;
    localparam logic [2:0] c_st_low      = 3'd2;
    localparam logic [2:0] c_st_high     = 3'd3;
    localparam logic [2:0] c_st_byte_end = 3'd4;

    // Number of bytes in a sequence; unused selectors are empty
    function automatic logic [3:0] seq_len(input logic [2:0] sel, input logic [3:0] dummy_len);
        logic [3:0] len;
        len = 4'd0;
        case (sel)
            DS_DUMMY: len = dummy_len;
            DS_MEAS:  len = c_len_meas;
            DS_READ:  len = c_len_read;
            DS_SRST:  len = c_len_srst;
            default:  len = 4'd0;
        endcase
        return len;
    endfunction

    // Byte transmitted at position idx of sequence sel
    function automatic logic [7:0] seq_byte(input logic [2:0] sel, input logic [3:0] idx);
        logic [7:0] b;
        b = c_cmd_dummy;
        case (sel)
            DS_MEAS: b = (idx == 4'd0) ? c_cmd_meas_0 : c_cmd_meas_1;
            DS_READ: b = c_cmd_read;
            DS_SRST: b = (idx == 4'd0) ? c_cmd_srst_0 : c_cmd_srst_1;
            default: b = c_cmd_dummy;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clk_div.sv
`default_nettype none
// ============================================================================
// Module      : spi_clk_div
// Description : SCLK half-period timer. While enabled it counts CLK_DIV clk
//               cycles and pulses o_tick on the last cycle of each half
//               period. Disabled or cleared, it rests at zero so every phase
//               starts with a full half period.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    localparam int              c_cw   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cw-1:0] c_last = c_cw'(CLK_DIV - 1);

    logic [c_cw-1:0] r_cnt;

    assign o_tick = i_enable && (r_cnt == c_last);

    // Half-period counter, restarts after each tick and whenever idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clear || !i_enable || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_byte_engine.sv
`default_nettype none
// ============================================================================
// Module      : spi_byte_engine
// Description : Serialises the selected multi-byte command sequence on
//               SCLK/MOSI (mode 0, MSB first), optionally captures MISO per
//               byte, and pulses done at the end of the sequence. Chip
//               select is owned by the upstream sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_byte_engine
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int RX_BYTES = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       transfer,
    input  logic [2:0] data_select,
    input  logic       receive,
    input  logic       byte_reset,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       done,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [3:0] rx_index
);

    localparam logic [3:0] c_dummy_len = 4'(RX_BYTES);

    logic [2:0] r_state;
    logic [2:0] r_sel;
    logic [3:0] r_byte_idx;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_tx_sh;     // bits still to be sent after the one on mosi
    logic [7:0] r_rx_sh;
    logic       r_rx_en;

    logic       w_tick;
    logic       w_div_en;
    logic [2:0] w_sel;
    logic [7:0] w_load_byte;
    logic [3:0] w_idx_next;

    // data_select only matters at frame start; resumed frames keep their latch
    assign w_sel       = (r_byte_idx == 4'd0) ? data_select : r_sel;
    assign w_load_byte = seq_byte(w_sel, r_byte_idx);
    assign w_idx_next  = r_byte_idx + 4'd1;
    assign w_div_en    = (r_state == c_st_low) || (r_state == c_st_high);
    assign busy        = (r_state != c_st_idle);

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (byte_reset),
        .i_enable (w_div_en),
        .o_tick   (w_tick)
    );

    // Byte sequencing FSM with registered SPI and receive outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_st_idle;
            r_sel      <= DS_DUMMY;
            r_byte_idx <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_tx_sh    <= 7'd0;
            r_rx_sh    <= 8'd0;
            r_rx_en    <= 1'b0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            done       <= 1'b0;
            rx_data    <= 8'd0;
            rx_valid   <= 1'b0;
            rx_index   <= 4'd0;
        end else begin
            done     <= 1'b0;
            rx_valid <= 1'b0;
            if (byte_reset) begin
                // Abort wins over everything, including a done due this cycle
                r_state    <= c_st_idle;
                r_byte_idx <= 4'd0;
                r_bit_cnt  <= 3'd0;
                sclk       <= 1'b0;
                mosi       <= 1'b0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (transfer) begin
                            // Empty sequences complete immediately without clocking
                            if ((r_byte_idx == 4'd0) &&
                                (seq_len(data_select, c_dummy_len) == 4'd0)) begin
                                done <= 1'b1;
                            end else begin
                                r_state <= c_st_load;
                            end
                        end
                    end
                    c_st_load: begin
                        r_sel     <= w_sel;
                        mosi      <= w_load_byte[7];
                        r_tx_sh   <= w_load_byte[6:0];
                        r_rx_en   <= receive;
                        r_bit_cnt <= 3'd0;
                        r_state   <= c_st_low;
                    end
                    c_st_low: begin
                        if (w_tick) begin
                            // Rising edge: sample MISO
                            sclk    <= 1'b1;
                            r_rx_sh <= {r_rx_sh[6:0], miso};
                            r_state <= c_st_high;
                        end
                    end
                    c_st_high: begin
                        if (w_tick) begin
                            // Falling edge: present the next bit, if any
                            sclk <= 1'b0;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= c_st_byte_end;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                mosi      <= r_tx_sh[6];
                                r_tx_sh   <= {r_tx_sh[5:0], 1'b0};
                                r_state   <= c_st_low;
                            end
                        end
                    end
                    c_st_byte_end: begin
                        if (r_rx_en) begin
                            rx_valid <= 1'b1;
                            rx_data  <= r_rx_sh;
                            rx_index <= r_byte_idx;
                        end
                        if (w_idx_next == seq_len(r_sel, c_dummy_len)) begin
                            done       <= 1'b1;
                            r_byte_idx <= 4'd0;
                            r_state    <= c_st_idle;
                        end else begin
                            // Without transfer, park here and resume on the next request
                            r_byte_idx <= w_idx_next;
                            r_state    <= transfer ? c_st_load : c_st_idle;
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
